// File: rtl/shifter_pipe_if.sv
// Valid/ready operand and result bus for shifter_pipe.
// slave is the shifter side, master is the producer/consumer side.
interface shifter_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
    logic             carry;
    logic             zero;

    modport slave (
        input  in_valid, d_in, op, shamt, out_ready,
        output in_ready, out_valid, d_out, carry, zero
    );

    modport master (
        output in_valid, d_in, op, shamt, out_ready,
        input  in_ready, out_valid, d_out, carry, zero
    );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry and zero flags
// and a valid/ready handshake on both sides.
module shifter_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           reset_n,
    shifter_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OpLsl = 2'b00,
        OpLsr = 2'b01,
        OpAsr = 2'b10,
        OpRor = 2'b11
    } op_e;

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [SHW-1:0]   s1_shamt_q, s1_shamt_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_carry_q, s2_carry_d;

    logic             adv2;
    logic             in_ready;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] shift_res;
    logic             shift_carry;
    logic             fill;
    logic [SHW-1:0]   shamt_m1;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    assign adv2     = !v2_q || bus.out_ready;
    assign in_ready = !v1_q || adv2;

    // Left shifts run through the right-shift network on a bit-reversed operand,
    // so a single log2(WIDTH)-level right-shift/rotate mux chain serves all ops.
    always_comb begin
        src  = (s1_op_q == OpLsl) ? bit_rev(s1_data_q) : s1_data_q;
        fill = (s1_op_q == OpAsr) && s1_data_q[WIDTH-1];
        lvl  = src;
        for (int k = 0; k < SHW; k++) begin
            if (s1_shamt_q[k]) begin
                if (s1_op_q == OpRor) begin
                    lvl = (lvl >> (1 << k)) | (lvl << (WIDTH - (1 << k)));
                end else begin
                    lvl = (lvl >> (1 << k)) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << k)));
                end
            end
        end
        shift_res = (s1_op_q == OpLsl) ? bit_rev(lvl) : lvl;

        // Last bit out is src[shamt-1]; for LSL that maps to d_in[WIDTH-shamt].
        shamt_m1 = s1_shamt_q - SHW'(1);
        if (s1_shamt_q == '0) begin
            shift_carry = 1'b0;
        end else if (s1_op_q == OpRor) begin
            shift_carry = shift_res[WIDTH-1];
        end else begin
            shift_carry = src[shamt_m1];
        end
    end

    always_comb begin
        v1_d       = v1_q;
        s1_data_d  = s1_data_q;
        s1_op_d    = s1_op_q;
        s1_shamt_d = s1_shamt_q;
        v2_d       = v2_q;
        s2_data_d  = s2_data_q;
        s2_carry_d = s2_carry_q;
        if (adv2) begin
            v2_d       = v1_q;
            s2_data_d  = shift_res;
            s2_carry_d = shift_carry;
        end
        if (in_ready) begin
            v1_d       = bus.in_valid;
            s1_data_d  = bus.d_in;
            s1_op_d    = bus.op;
            s1_shamt_d = bus.shamt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q       <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= '0;
            s1_shamt_q <= '0;
            v2_q       <= 1'b0;
            s2_data_q  <= '0;
            s2_carry_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            s1_data_q  <= s1_data_d;
            s1_op_q    <= s1_op_d;
            s1_shamt_q <= s1_shamt_d;
            v2_q       <= v2_d;
            s2_data_q  <= s2_data_d;
            s2_carry_q <= s2_carry_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v2_q;
    assign bus.d_out     = s2_data_q;
    assign bus.carry     = s2_carry_q;
    // Gated by v2 so an empty pipe never reports a zero result.
    assign bus.zero      = v2_q && (s2_data_q == '0);
endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: directed table and corner sequences at WIDTH=8,
// randomized handshake stream against a per-bit reference model at WIDTH=32.
module tb_shifter_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    shifter_pipe_if #(.WIDTH(8))  bus8 ();
    shifter_pipe_if #(.WIDTH(32)) bus32 ();

    shifter_pipe #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    shifter_pipe #(.WIDTH(32)) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus32)
    );

    typedef struct {
        logic [1:0]  op;
        logic [63:0] d;
        int          s;
        logic [63:0] e_d;
        logic        e_c;
    } vec_t;

    vec_t tbl [13];
    vec_t pend8[$];
    vec_t exp8[$];
    vec_t pend32[$];
    vec_t exp32[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Result bit i and carry straight from the operation definitions.
    function automatic logic [64:0] ref_shift(int w, logic [1:0] op, logic [63:0] d, int s);
        logic [63:0] r = '0;
        logic        c;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
                2'b01:   r[i] = (i + s < w) ? d[i+s] : 1'b0;
                2'b10:   r[i] = (i + s < w) ? d[i+s] : d[w-1];
                default: r[i] = d[(i+s)%w];
            endcase
        end
        if (s == 0) c = 1'b0;
        else if (op == 2'b00) c = d[w-s];
        else if (op == 2'b11) c = r[w-1];
        else c = d[s-1];
        return {c, r};
    endfunction

    function automatic vec_t mk(int w, logic [1:0] op, logic [63:0] d, int s);
        vec_t        v;
        logic [64:0] r;
        r     = ref_shift(w, op, d, s);
        v.op  = op;
        v.d   = d;
        v.s   = s;
        v.e_d = r[63:0];
        v.e_c = r[64];
        return v;
    endfunction

    // Streams pend8 through the 8-bit DUT; out_ready held low for the first `low` cycles.
    task automatic run8(input int low, output int acc_low, output logic rdy_last);
        int         cyc = 0;
        int         idx = 0;
        bit         seen = 0;
        bit         held_ok = 0;
        logic [7:0] held = '0;
        vec_t       e;
        acc_low  = 0;
        rdy_last = 1'b1;
        while ((pend8.size() > 0 || exp8.size() > 0) && cyc < 300) begin
            @(posedge clk);
            #1;
            bus8.out_ready = (cyc >= low);
            if (pend8.size() > 0) begin
                bus8.in_valid = 1'b1;
                bus8.op       = pend8[0].op;
                bus8.d_in     = pend8[0].d[7:0];
                bus8.shamt    = 3'(pend8[0].s);
            end else begin
                bus8.in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < low) begin
                rdy_last = bus8.in_ready;
                if (bus8.out_valid) begin
                    if (held_ok) check("stall_hold_dout", 64'(bus8.d_out), 64'(held));
                    held    = bus8.d_out;
                    held_ok = 1;
                end
            end
            if (bus8.out_valid && bus8.out_ready) begin
                e = exp8.pop_front();
                check($sformatf("res%0d_dout", idx), 64'(bus8.d_out), e.e_d);
                check($sformatf("res%0d_carry", idx), 64'(bus8.carry), 64'(e.e_c));
                check($sformatf("res%0d_zero", idx), 64'(bus8.zero), 64'(e.e_d == 0));
                idx++;
                seen = 1;
            end else if (seen && low == 0 && exp8.size() > 0) begin
                check("no_bubble_out_valid", 64'(bus8.out_valid), 64'd1);
            end
            if (bus8.in_valid && bus8.in_ready) begin
                exp8.push_back(pend8.pop_front());
                if (cyc < low) acc_low++;
            end
            cyc++;
        end
        check("run8_drained", 64'(pend8.size() + exp8.size()), 64'd0);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic run32();
        int          cyc = 0;
        int          idx = 0;
        bit          hold_pend = 0;
        logic [31:0] hold_val = '0;
        vec_t        e;
        while ((pend32.size() > 0 || exp32.size() > 0) && cyc < 5000) begin
            @(posedge clk);
            #1;
            bus32.out_ready = ($urandom_range(0, 3) != 0);
            bus32.in_valid  = (pend32.size() > 0) && ($urandom_range(0, 4) != 0);
            if (pend32.size() > 0) begin
                bus32.op    = pend32[0].op;
                bus32.d_in  = pend32[0].d[31:0];
                bus32.shamt = 5'(pend32[0].s);
            end
            @(negedge clk);
            if (hold_pend) begin
                check("w32_hold_valid", 64'(bus32.out_valid), 64'd1);
                check("w32_hold_dout", 64'(bus32.d_out), 64'(hold_val));
            end
            hold_pend = bus32.out_valid && !bus32.out_ready;
            hold_val  = bus32.d_out;
            if (bus32.out_valid && bus32.out_ready) begin
                e = exp32.pop_front();
                check($sformatf("w32_%0d_dout", idx), 64'(bus32.d_out), e.e_d);
                check($sformatf("w32_%0d_carry", idx), 64'(bus32.carry), 64'(e.e_c));
                check($sformatf("w32_%0d_zero", idx), 64'(bus32.zero), 64'(e.e_d == 0));
                idx++;
            end
            if (bus32.in_valid && bus32.in_ready) exp32.push_back(pend32.pop_front());
            cyc++;
        end
        check("run32_drained", 64'(pend32.size() + exp32.size()), 64'd0);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int   acc;
        logic rdy;

        // {op, d_in, shamt, d_out, carry}; zero is implied by d_out
        tbl[0]  = '{2'b10, 64'h96, 3, 64'hF2, 1'b1};
        tbl[1]  = '{2'b00, 64'h96, 3, 64'hB0, 1'b0};
        tbl[2]  = '{2'b01, 64'h96, 3, 64'h12, 1'b1};
        tbl[3]  = '{2'b11, 64'h96, 3, 64'hD2, 1'b1};
        tbl[4]  = '{2'b01, 64'h01, 1, 64'h00, 1'b1};
        tbl[5]  = '{2'b00, 64'hA5, 0, 64'hA5, 1'b0};
        tbl[6]  = '{2'b01, 64'hA5, 0, 64'hA5, 1'b0};
        tbl[7]  = '{2'b10, 64'hA5, 0, 64'hA5, 1'b0};
        tbl[8]  = '{2'b11, 64'hA5, 0, 64'hA5, 1'b0};
        tbl[9]  = '{2'b10, 64'h80, 7, 64'hFF, 1'b0};
        tbl[10] = '{2'b00, 64'h03, 7, 64'h80, 1'b1};
        tbl[11] = '{2'b11, 64'h01, 1, 64'h80, 1'b1};
        tbl[12] = '{2'b10, 64'h7F, 7, 64'h00, 1'b1};

        {bus8.in_valid, bus8.out_ready, bus8.op, bus8.shamt, bus8.d_in} = '0;
        {bus32.in_valid, bus32.out_ready, bus32.op, bus32.shamt, bus32.d_in} = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", 64'(bus8.out_valid), 64'd0);
        check("reset_dout", 64'(bus8.d_out), 64'd0);
        check("reset_carry", 64'(bus8.carry), 64'd0);
        check("reset_zero", 64'(bus8.zero), 64'd0);
        check("reset_in_ready", 64'(bus8.in_ready), 64'd1);

        // Single ASR: out_valid rises on the second edge counting the accepting one.
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.op        = 2'b10;
        bus8.d_in      = 8'h96;
        bus8.shamt     = 3'd3;
        @(negedge clk);
        check("lat_in_ready", 64'(bus8.in_ready), 64'd1);
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1_out_valid", 64'(bus8.out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge2_out_valid", 64'(bus8.out_valid), 64'd1);
        check("lat_dout", 64'(bus8.d_out), 64'hF2);
        check("lat_carry", 64'(bus8.carry), 64'd1);
        check("lat_zero", 64'(bus8.zero), 64'd0);

        // Back-to-back table stream with out_ready high.
        for (int i = 0; i < 13; i++) pend8.push_back(tbl[i]);
        run8(0, acc, rdy);

        // Backpressure: 5 ops, out_ready low for 4 cycles.
        pend8.push_back(mk(8, 2'b00, 64'h5C, 2));
        pend8.push_back(mk(8, 2'b01, 64'hC3, 5));
        pend8.push_back(mk(8, 2'b10, 64'h9A, 1));
        pend8.push_back(mk(8, 2'b11, 64'h3C, 6));
        pend8.push_back(mk(8, 2'b10, 64'hE1, 4));
        run8(4, acc, rdy);
        check("bp_accepts_while_stalled", 64'(acc), 64'd2);
        check("bp_in_ready_stalled", 64'(rdy), 64'd0);

        // Reset with two ops in flight.
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.op        = 2'b01;
        bus8.d_in      = 8'hFF;
        bus8.shamt     = 3'd1;
        @(posedge clk);
        #1;
        bus8.op    = 2'b11;
        bus8.d_in  = 8'h0F;
        bus8.shamt = 3'd4;
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_out_valid", 64'(bus8.out_valid), 64'd1);
        check("rst_pre_dout", 64'(bus8.d_out), 64'h7F);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_async_dout", 64'(bus8.d_out), 64'd0);
        check("rst_async_carry", 64'(bus8.carry), 64'd0);
        check("rst_async_zero", 64'(bus8.zero), 64'd0);
        check("rst_async_in_ready", 64'(bus8.in_ready), 64'd1);
        #1 reset_n = 1'b1;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale_out_valid", 64'(bus8.out_valid), 64'd0);
        end
        check("rst_after_in_ready", 64'(bus8.in_ready), 64'd1);

        // WIDTH=32: sign-fill corner, then every op x shamt with random data.
        pend32.push_back('{2'b10, 64'h8000_0000, 31, 64'hFFFF_FFFF, 1'b0});
        pend32.push_back(mk(32, 2'b01, 64'h0000_0001, 1));
        pend32.push_back(mk(32, 2'b00, 64'hFFFF_FFFF, 31));
        for (int op = 0; op < 4; op++) begin
            for (int s = 0; s < 32; s++) begin
                for (int r = 0; r < 2; r++) begin
                    pend32.push_back(mk(32, 2'(op), {32'h0, $urandom()}, s));
                end
            end
        end
        run32();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
